// File: rtl/pwm_config_shadow_if.sv
// rtl/pwm_config_shadow_if.sv - register-side handshake bundle for pwm_config_shadow
// Signals:
//   cfg_in       packed configuration word from the config-register stage
//   cfg_wr       1-cycle strobe, capture cfg_in into the pending register
//   tout_clr     clears the sticky timeout flag
//   upd_pending  high while a written word waits for its apply point
//   upd_done     1-cycle pulse in the cycle the active word changes
//   upd_timeout  sticky, last apply was forced by the timeout
// Modports: master = register/bus side, slave = pwm_config_shadow.
interface pwm_config_shadow_if #(
   parameter int CFG_WIDTH = 16
);
   logic [CFG_WIDTH-1:0] cfg_in;
   logic                 cfg_wr;
   logic                 tout_clr;
   logic                 upd_pending;
   logic                 upd_done;
   logic                 upd_timeout;

   modport master (
      output cfg_in, cfg_wr, tout_clr,
      input  upd_pending, upd_done, upd_timeout
   );

   modport slave (
      input  cfg_in, cfg_wr, tout_clr,
      output upd_pending, upd_done, upd_timeout
   );
endinterface

// File: rtl/pwm_config_shadow.sv
// rtl/pwm_config_shadow.sv - shadowed PWM config word, applied only at a safe carrier boundary
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   bus (slave)          cfg_in/cfg_wr/tout_clr in, upd_pending/upd_done/upd_timeout out
//   i_carrier_zero       1-cycle pulse, carrier counter at 0
//   i_carrier_max        1-cycle pulse, carrier counter at period
//   o_cfg_active         active configuration word
//   o_count_mode .. o_logic_b  decoded bits [0]..[7] of the active word
module pwm_config_shadow #(
   parameter int                   CFG_WIDTH   = 16,
   parameter logic [CFG_WIDTH-1:0] RESET_CFG   = '0,
   parameter int                   UPDATE_AT   = 0,
   parameter int                   TIMEOUT_CYC = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   pwm_config_shadow_if.slave   bus,
   input  logic                 i_carrier_zero,
   input  logic                 i_carrier_max,
   output logic [CFG_WIDTH-1:0] o_cfg_active,
   output logic                 o_count_mode,
   output logic                 o_mask_mode,
   output logic                 o_dtclkdiv_onoff,
   output logic                 o_pwmclkdiv_onoff,
   output logic                 o_int_onoff,
   output logic                 o_pwm_onoff,
   output logic                 o_logic_a,
   output logic                 o_logic_b
);

   // A zero timeout still needs a 1-bit counter so the declarations stay legal.
   localparam int              TW        = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam bit              TOUT_EN   = (TIMEOUT_CYC != 0);
   localparam logic [TW-1:0]   TOUT_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CFG_WIDTH-1:0] r_pending;
   logic [CFG_WIDTH-1:0] r_active;
   logic [TW-1:0]        r_tout_cnt;
   logic                 r_upd_done;
   logic                 r_upd_timeout;

   logic                 w_boundary;
   logic                 w_stopped;
   logic                 w_forced;
   logic                 w_apply;
   logic                 w_set_tout;

   always_comb begin
      case (UPDATE_AT)
         0:       w_boundary = i_carrier_zero;
         1:       w_boundary = i_carrier_max;
         2:       w_boundary = i_carrier_zero | i_carrier_max;
         default: w_boundary = 1'b0;
      endcase
   end

   // With the PWM output off there is no period to protect, so apply at once.
   assign w_stopped = ~r_active[5];

   always_comb begin
      w_state_nxt = r_state;
      w_forced    = 1'b0;
      w_apply     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.cfg_wr) begin
               w_state_nxt = ST_PENDING;
            end
         end
         ST_PENDING: begin
            w_forced = TOUT_EN && (r_tout_cnt == TOUT_LAST);
            w_apply  = w_boundary | w_stopped | w_forced;
            // A write landing on the apply cycle becomes the next pending word.
            if (w_apply && !bus.cfg_wr) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Only flag a timeout when nothing else would have applied this cycle.
   assign w_set_tout = w_apply & w_forced & ~w_boundary & ~w_stopped;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_pending     <= RESET_CFG;
         r_active      <= RESET_CFG;
         r_tout_cnt    <= '0;
         r_upd_done    <= 1'b0;
         r_upd_timeout <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_upd_done <= w_apply;
         if (bus.cfg_wr) begin
            r_pending <= bus.cfg_in;
         end
         if (w_apply) begin
            r_active <= r_pending;
         end
         // Overwrites keep counting so a steady stream of writes cannot starve the apply.
         if (r_state != ST_PENDING || w_apply) begin
            r_tout_cnt <= '0;
         end else if (r_tout_cnt != {TW{1'b1}}) begin
            r_tout_cnt <= r_tout_cnt + 1'b1;
         end
         if (w_set_tout) begin
            r_upd_timeout <= 1'b1;
         end else if (bus.tout_clr) begin
            r_upd_timeout <= 1'b0;
         end
      end
   end

   assign bus.upd_pending = (r_state == ST_PENDING);
   assign bus.upd_done    = r_upd_done;
   assign bus.upd_timeout = r_upd_timeout;

   assign o_cfg_active      = r_active;
   assign o_count_mode      = r_active[0];
   assign o_mask_mode       = r_active[1];
   assign o_dtclkdiv_onoff  = r_active[2];
   assign o_pwmclkdiv_onoff = r_active[3];
   assign o_int_onoff       = r_active[4];
   assign o_pwm_onoff       = r_active[5];
   assign o_logic_a         = r_active[6];
   assign o_logic_b         = r_active[7];

endmodule

// File: tb/tb_pwm_config_shadow.sv
// tb/tb_pwm_config_shadow.sv - scoreboard bench for pwm_config_shadow
module tb_pwm_config_shadow;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // DUT A: carrier-zero boundary, long timeout. DUT B: carrier-max boundary, timeout 8.
   pwm_config_shadow_if #(.CFG_WIDTH(16)) if_a ();
   pwm_config_shadow_if #(.CFG_WIDTH(16)) if_b ();

   logic        cz_a = 1'b0, cm_a = 1'b0, cz_b = 1'b0, cm_b = 1'b0;
   logic [15:0] act_a, act_b;
   logic [7:0]  dec_a, dec_b;

   pwm_config_shadow #(.CFG_WIDTH(16), .RESET_CFG(16'h0000), .UPDATE_AT(0), .TIMEOUT_CYC(64)) u_dut_a (
      .clk(clk), .rst(rst), .bus(if_a.slave),
      .i_carrier_zero(cz_a), .i_carrier_max(cm_a),
      .o_cfg_active(act_a),
      .o_count_mode(dec_a[0]), .o_mask_mode(dec_a[1]), .o_dtclkdiv_onoff(dec_a[2]),
      .o_pwmclkdiv_onoff(dec_a[3]), .o_int_onoff(dec_a[4]), .o_pwm_onoff(dec_a[5]),
      .o_logic_a(dec_a[6]), .o_logic_b(dec_a[7])
   );

   pwm_config_shadow #(.CFG_WIDTH(16), .RESET_CFG(16'h0000), .UPDATE_AT(1), .TIMEOUT_CYC(8)) u_dut_b (
      .clk(clk), .rst(rst), .bus(if_b.slave),
      .i_carrier_zero(cz_b), .i_carrier_max(cm_b),
      .o_cfg_active(act_b),
      .o_count_mode(dec_b[0]), .o_mask_mode(dec_b[1]), .o_dtclkdiv_onoff(dec_b[2]),
      .o_pwmclkdiv_onoff(dec_b[3]), .o_int_onoff(dec_b[4]), .o_pwm_onoff(dec_b[5]),
      .o_logic_a(dec_b[6]), .o_logic_b(dec_b[7])
   );

   typedef struct {
      int          dut;
      logic [15:0] val;
      int          at_cyc;
      logic        tout;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] prev_act [2];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push(input int dut, input logic [15:0] val, input int at_cyc, input logic tout);
      exp_t e;
      e.dut = dut; e.val = val; e.at_cyc = at_cyc; e.tout = tout;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mon_dut(input int id, input logic done, input logic [15:0] act,
                          input logic [7:0] dec, input logic tout);
      exp_t e;
      if (act !== prev_act[id] && !done) begin
         chk($sformatf("dut%0d_change_without_done", id), act, prev_act[id]);
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            chk($sformatf("dut%0d_unexpected_done", id), 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("dut%0d_done_dut", id), id, e.dut);
            chk($sformatf("dut%0d_active", id), act, e.val);
            chk($sformatf("dut%0d_decoded", id), dec, e.val[7:0]);
            chk($sformatf("dut%0d_done_cycle", id), cyc, e.at_cyc);
            chk($sformatf("dut%0d_timeout_flag", id), tout, e.tout);
         end
      end
      prev_act[id] = act;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_act[0] = act_a;
         prev_act[1] = act_b;
      end else begin
         mon_dut(0, if_a.upd_done, act_a, dec_a, if_a.upd_timeout);
         mon_dut(1, if_b.upd_done, act_b, dec_b, if_b.upd_timeout);
      end
   end

   initial begin
      #200000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      int c0;
      if_a.cfg_in = '0; if_a.cfg_wr = 1'b0; if_a.tout_clr = 1'b0;
      if_b.cfg_in = '0; if_b.cfg_wr = 1'b0; if_b.tout_clr = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      chk("reset_active_a", act_a, 16'h0000);
      chk("reset_pending_a", if_a.upd_pending, 1'b0);
      chk("reset_timeout_a", if_a.upd_timeout, 1'b0);
      step();

      // Stopped apply: active 0, write 21 at c0 -> applied at c0+2.
      c0 = cyc;
      if_a.cfg_in = 16'h0021; if_a.cfg_wr = 1'b1;
      push(0, 16'h0021, c0 + 2, 1'b0);
      step();
      if_a.cfg_wr = 1'b0;
      chk("stopped_pending_a", if_a.upd_pending, 1'b1);
      repeat (3) step();

      // Boundary apply after 20 cycles of waiting.
      c0 = cyc;
      if_a.cfg_in = 16'h0025; if_a.cfg_wr = 1'b1;
      push(0, 16'h0025, c0 + 21, 1'b0);
      step();
      if_a.cfg_wr = 1'b0;
      repeat (19) step();
      cz_a = 1'b1;
      step();
      cz_a = 1'b0;
      repeat (3) step();

      // Carrier pulse in the write cycle itself does not apply that write.
      c0 = cyc;
      if_a.cfg_in = 16'h0027; if_a.cfg_wr = 1'b1; cz_a = 1'b1;
      push(0, 16'h0027, c0 + 4, 1'b0);
      step();
      if_a.cfg_wr = 1'b0; cz_a = 1'b0;
      step();
      step();
      cz_a = 1'b1;
      step();
      cz_a = 1'b0;
      repeat (3) step();

      // Write coinciding with apply: old pending applied, new one stays pending.
      c0 = cyc;
      if_a.cfg_in = 16'h0024; if_a.cfg_wr = 1'b1;
      push(0, 16'h0024, c0 + 11, 1'b0);
      step();
      if_a.cfg_wr = 1'b0;
      repeat (9) step();
      if_a.cfg_in = 16'h0026; if_a.cfg_wr = 1'b1; cz_a = 1'b1;
      push(0, 16'h0026, c0 + 16, 1'b0);
      step();
      if_a.cfg_wr = 1'b0; cz_a = 1'b0;
      chk("same_cycle_pending_a", if_a.upd_pending, 1'b1);
      chk("same_cycle_active_a", act_a, 16'h0024);
      repeat (4) step();
      cz_a = 1'b1;
      step();
      cz_a = 1'b0;
      chk("idle_after_apply_a", if_a.upd_pending, 1'b0);
      repeat (3) step();

      // Asynchronous reset in the middle of a pending update.
      if_a.cfg_in = 16'h0022; if_a.cfg_wr = 1'b1;
      step();
      if_a.cfg_wr = 1'b0;
      step();
      chk("pre_reset_pending_a", if_a.upd_pending, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_active_a", act_a, 16'h0000);
      chk("async_reset_pending_a", if_a.upd_pending, 1'b0);
      step();
      step();
      rst = 1'b0;
      step();

      // DUT B: start it running via a stopped apply.
      c0 = cyc;
      if_b.cfg_in = 16'h0020; if_b.cfg_wr = 1'b1;
      push(1, 16'h0020, c0 + 2, 1'b0);
      step();
      if_b.cfg_wr = 1'b0;
      repeat (3) step();

      // Timeout: 8 cycles, no carrier pulses -> forced apply at c0+9.
      c0 = cyc;
      if_b.cfg_in = 16'h0030; if_b.cfg_wr = 1'b1;
      push(1, 16'h0030, c0 + 9, 1'b1);
      step();
      if_b.cfg_wr = 1'b0;
      repeat (11) step();
      chk("timeout_sticky_b", if_b.upd_timeout, 1'b1);
      if_b.tout_clr = 1'b1;
      step();
      if_b.tout_clr = 1'b0;
      chk("timeout_cleared_b", if_b.upd_timeout, 1'b0);
      step();

      // Carrier-max boundary: carrier_zero is ignored.
      c0 = cyc;
      if_b.cfg_in = 16'h0031; if_b.cfg_wr = 1'b1;
      push(1, 16'h0031, c0 + 6, 1'b0);
      step();
      if_b.cfg_wr = 1'b0;
      step();
      cz_b = 1'b1;
      step();
      cz_b = 1'b0;
      chk("zero_ignored_b", if_b.upd_pending, 1'b1);
      step();
      step();
      cm_b = 1'b1;
      step();
      cm_b = 1'b0;
      repeat (4) step();

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
